// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write/read port schedulers.
// Holds the arbiter state encoding and the round-robin pointer wrap.
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Explicit wrap so non-power-of-two requester counts stay in range.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo N. Shared by the write arbiter and the read-side scheduler.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic          found;
  logic [PW-1:0] cand;

  assign any = |valid;

  // Walk the ring starting at ptr; the first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      cand = PW'(rr_next(32'(cand), N));
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among N_REQ requesters.
// Grants are held per burst until last beat, beat limit, or idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int D_WIDTH      = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*D_WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_w_inc,
  output logic [D_WIDTH-1:0]          fifo_w_data,
  input  logic                        fifo_w_full,
  output logic                        grant_vld,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        timeout_pulse
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, grant_id_nxt;
  logic [BW-1:0]      beat_cnt, beat_cnt_nxt;
  logic [TW-1:0]      idle_cnt, idle_cnt_nxt;
  logic               timeout_nxt;
  logic               pick_any;
  logic [IW-1:0]      pick_idx;
  logic [D_WIDTH-1:0] req_slice [N_REQ];
  logic               gnt_valid, gnt_last, xfer, limit_hit, idle_expired;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign req_slice[i] = req_data[i*D_WIDTH +: D_WIDTH];
  end

  rr_pick #(
    .N  (N_REQ),
    .PW (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  assign gnt_valid    = req_valid[grant_id];
  assign gnt_last     = req_last[grant_id];
  assign xfer         = (state == BURST) && gnt_valid && !fifo_w_full;
  assign limit_hit    = (beat_cnt == BW'(MAX_BURST - 1));
  assign idle_expired = (idle_cnt == TW'(IDLE_TIMEOUT - 1));
  assign grant_vld    = (state == BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB;
      rr_ptr        <= '0;
      grant_id      <= '0;
      beat_cnt      <= '0;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant_id      <= grant_id_nxt;
      beat_cnt      <= beat_cnt_nxt;
      idle_cnt      <= idle_cnt_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

  // Full-stalled cycles with valid high clear the idle count, so a held
  // w_full never times the grant out.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_id_nxt = grant_id;
    beat_cnt_nxt = beat_cnt;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      ARB: begin
        if (pick_any) begin
          grant_id_nxt = pick_idx;
          beat_cnt_nxt = '0;
          idle_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (gnt_valid) begin
          idle_cnt_nxt = '0;
        end else if (idle_expired) begin
          timeout_nxt = 1'b1;
          rr_ptr_nxt  = IW'(rr_next(32'(grant_id), N_REQ));
          state_nxt   = ARB;
        end else begin
          idle_cnt_nxt = idle_cnt + TW'(1);
        end
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + BW'(1);
          if (gnt_last || limit_hit) begin
            rr_ptr_nxt = IW'(rr_next(32'(grant_id), N_REQ));
            state_nxt  = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    fifo_w_inc  = 1'b0;
    fifo_w_data = '0;
    if (state == BURST) begin
      req_ready[grant_id] = !fifo_w_full;
      fifo_w_inc          = xfer;
      fifo_w_data         = req_slice[grant_id];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (3 requesters, burst 4, timeout 8)
// against a behavioural per-cycle reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_last = '0;
  logic [23:0] req_data = '0;
  logic        fifo_w_full = 1'b0;
  logic [2:0]  req_ready;
  logic        fifo_w_inc;
  logic [7:0]  fifo_w_data;
  logic        grant_vld;
  logic [1:0]  grant_id;
  logic        timeout_pulse;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port, where the next search starts,
  // beats taken in this grant and consecutive idle cycles so far.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;
  int m_idle;
  bit m_pulse;

  logic [15:0] obs;

  fifo_wr_arbiter #(
    .N_REQ        (N),
    .D_WIDTH      (DW),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_w_inc    (fifo_w_inc),
    .fifo_w_data   (fifo_w_data),
    .fifo_w_full   (fifo_w_full),
    .grant_vld     (grant_vld),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  assign obs = {grant_vld, grant_id, req_ready, fifo_w_inc, fifo_w_data, timeout_pulse};

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_beats = 0;
    m_idle  = 0;
    m_pulse = 1'b0;
  endfunction

  function automatic bit model_accepts();
    logic [1:0] o;
    o = 2'(m_owner);
    return m_busy && req_valid[o] && !fifo_w_full;
  endfunction

  function automatic logic [15:0] model_out();
    logic [2:0] rdy;
    logic       inc;
    logic [7:0] d;
    rdy = '0;
    inc = 1'b0;
    d   = '0;
    if (m_busy) begin
      if (!fifo_w_full) rdy = 3'(1 << m_owner);
      inc = model_accepts();
      d   = 8'(req_data >> (8 * m_owner));
    end
    return {m_busy, 2'(m_owner), rdy, inc, d, m_pulse};
  endfunction

  function automatic void model_advance();
    logic [1:0] o;
    bit         hit;
    o       = 2'(m_owner);
    m_pulse = 1'b0;
    if (!m_busy) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!hit && req_valid[2'((m_ptr + k) % N)]) begin
          m_owner = (m_ptr + k) % N;
          hit     = 1'b1;
        end
      end
      if (hit) begin
        m_busy  = 1'b1;
        m_beats = 0;
        m_idle  = 0;
      end
    end else if (req_valid[o] && !fifo_w_full) begin
      m_beats++;
      m_idle = 0;
      if (req_last[o] || m_beats == MB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (req_valid[o]) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IT) begin
        m_pulse = 1'b1;
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % N;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_advance();
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    req_valid   = '0;
    req_last    = '0;
    req_data    = '0;
    fifo_w_full = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    tick();
    tick();
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h exp=%h", obs, 16'h0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
    end
  endtask

  task automatic test_fairness();
    int pkt[3];
    int exp_order[4];
    int order_idx;
    bit prev;
    pkt       = '{0, 0, 0};
    exp_order = '{0, 1, 2, 0};
    order_idx = 0;
    prev      = 1'b0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = 3'b111;
      req_last  = {pkt[2] == 1, pkt[1] == 1, pkt[0] == 1};
      req_data  = 24'($urandom());
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL fairness cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (grant_vld && !prev) begin
        if (order_idx < 4) begin
          checks++;
          if (grant_id !== 2'(exp_order[order_idx])) begin
            failures++;
            $display("[TB] FAIL fairness_order n=%0d got=%0d exp=%0d", order_idx, grant_id, exp_order[order_idx]);
          end
        end
        order_idx++;
      end
      prev = grant_vld;
      if (model_accepts()) pkt[m_owner] = (pkt[m_owner] + 1) % 2;
      tick();
    end
    checks++;
    if (order_idx != 4) begin
      failures++;
      $display("[TB] FAIL fairness_grants got=%0d exp=4", order_idx);
    end
  endtask

  task automatic test_beat_limit();
    int         idx;
    logic [7:0] got[$];
    logic [7:0] e;
    idx = 0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      req_valid   = (idx < 6) ? 3'b010 : 3'b000;
      req_last    = '0;
      req_data    = {8'($urandom()), 8'(8'hA0 + idx), 8'($urandom())};
      fifo_w_full = 1'b0;
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL beat_limit cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 5) begin
        checks++;
        if (grant_vld !== 1'b0) begin
          failures++;
          $display("[TB] FAIL beat_limit_bubble got=%b exp=0", grant_vld);
        end
      end
      if (fifo_w_inc) begin
        got.push_back(fifo_w_data);
        checks++;
        if (grant_id !== 2'd1) begin
          failures++;
          $display("[TB] FAIL beat_limit_id got=%0d exp=1", grant_id);
        end
      end
      if (model_accepts()) idx++;
      tick();
    end
    checks++;
    if (got.size() != 6) begin
      failures++;
      $display("[TB] FAIL beat_limit_count got=%0d exp=6", got.size());
    end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      e = 8'(8'hA0 + k);
      checks++;
      if (got[k] !== e) begin
        failures++;
        $display("[TB] FAIL beat_limit_data n=%0d got=%h exp=%h", k, got[k], e);
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      req_valid   = 3'b001;
      req_last    = '0;
      req_data    = 24'($urandom());
      fifo_w_full = (c >= 2 && c < 22);
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL full_stall cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (fifo_w_full) begin
        checks++;
        if (fifo_w_inc !== 1'b0 || grant_vld !== 1'b1 || timeout_pulse !== 1'b0) begin
          failures++;
          $display("[TB] FAIL full_stall_hold cyc=%0d got=%b%b%b exp=010", c, fifo_w_inc, grant_vld, timeout_pulse);
        end
      end
      if (c == 22) begin
        checks++;
        if (fifo_w_inc !== 1'b1) begin
          failures++;
          $display("[TB] FAIL full_stall_resume got=%b exp=1", fifo_w_inc);
        end
      end
      tick();
    end
    fifo_w_full = 1'b0;
  endtask

  task automatic test_timeout();
    int first_pulse;
    int pulses;
    first_pulse = -1;
    pulses      = 0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 2) ? 3'b100 : ((c >= 10) ? 3'b011 : 3'b000);
      req_last  = '0;
      req_data  = 24'($urandom());
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL timeout cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (timeout_pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      if (c == 11) begin
        checks++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin
          failures++;
          $display("[TB] FAIL timeout_next_grant got=%b/%0d exp=1/0", grant_vld, grant_id);
        end
      end
      tick();
    end
    checks++;
    if (first_pulse != 10 || pulses != 1) begin
      failures++;
      $display("[TB] FAIL timeout_pulse at=%0d count=%0d exp at=10 count=1", first_pulse, pulses);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 3'b001;
      req_last  = '0;
      req_data  = 24'($urandom());
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL rst_mid_pre cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c < 2) tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rst_mid_async got=%h exp=%h", obs, 16'h0000);
    end
    model_reset();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 3'b011;
      req_data  = 24'($urandom());
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL rst_mid_post cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 1) begin
        checks++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin
          failures++;
          $display("[TB] FAIL rst_mid_grant got=%b/%0d exp=1/0", grant_vld, grant_id);
        end
      end
      tick();
    end
  endtask

  task automatic test_last_and_limit();
    int b0;
    b0 = 0;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      req_valid = (b0 < 4) ? 3'b111 : 3'b110;
      req_last  = {1'b0, 1'b0, b0 == 3};
      req_data  = 24'($urandom());
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL last_limit cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 5) begin
        checks++;
        if (grant_vld !== 1'b0) begin
          failures++;
          $display("[TB] FAIL last_limit_bubble got=%b exp=0", grant_vld);
        end
      end
      if (c == 6) begin
        checks++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin
          failures++;
          $display("[TB] FAIL last_limit_next got=%b/%0d exp=1/1", grant_vld, grant_id);
        end
      end
      if (model_accepts() && m_owner == 0) b0++;
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom());
      req_last    = 3'($urandom());
      req_data    = 24'($urandom());
      fifo_w_full = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_beat_limit();
    test_full_stall();
    test_timeout();
    test_reset_mid_burst();
    test_last_and_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the `async_fifo` among N requesters in the FIFO's write clock domain. It grants one requester at a time for a packet burst, holds the grant until the requester's last beat or a beat limit, and releases stalled grants on a timeout. It sits directly in front of the FIFO's `w_inc`/`w_data`/`w_full` pins.

## Interface
- `N_REQ`, default 4: number of requesters, at least 2.
- `D_WIDTH`, default 8: data width; must match the FIFO's `D_WIDTH`.
- `MAX_BURST`, default 16: maximum beats per grant, at least 1.
- `IDLE_TIMEOUT`, default 32: consecutive no-valid cycles that release a grant, at least 1.
- `clk` in 1: single clock, tied to the FIFO write clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester beat valid.
- `req_last` in N_REQ: per-requester last beat of packet; sampled only with valid.
- `req_data` in N_REQ*D_WIDTH: requester i occupies bits [i*D_WIDTH +: D_WIDTH].
- `req_ready` out N_REQ: one-hot or zero; beat accepted when valid && ready.
- `fifo_w_inc` out 1: to FIFO `w_inc`.
- `fifo_w_data` out D_WIDTH: to FIFO `w_data`.
- `fifo_w_full` in 1: from FIFO `w_full`.
- `grant_vld` out 1: a grant is held.
- `grant_id` out $clog2(N_REQ): index of the current or last grant.
- `timeout_pulse` out 1: one-cycle pulse when a grant is released by timeout.

## Operation
- FSM states are `ARB` and `BURST`. Reset state is `ARB`, with `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`, `idle_cnt=0`.
- **ARB state**
  - If any `req_valid` is high, pick the first valid index searching from `rr_ptr` upward, modulo N_REQ.
  - Register that index as `grant_id`, clear both counters, and go to `BURST`.
  - No beats are accepted in `ARB`: `req_ready=0` and `fifo_w_inc=0`.
- **BURST state**
  - `req_ready[grant_id] = !fifo_w_full`; all other ready bits are 0.
  - `fifo_w_inc = req_valid[grant_id] && !fifo_w_full`, which equals the transfer condition.
  - `fifo_w_data` is the `grant_id` slice of `req_data`. In `ARB` it is 0.
- **Burst end**
  - A burst ends on a transfer where `req_last` is high or `beat_cnt+1 == MAX_BURST`.
  - At the end: `rr_ptr <= (grant_id+1) mod N_REQ`, go to `ARB`.
- **Stall accounting**
  - `idle_cnt` increments on each `BURST` cycle with `req_valid[grant_id]` low.
  - It clears on any cycle where valid is high.
  - Cycles stalled by `fifo_w_full` with valid high do not count.
- **Timeout**: when `idle_cnt` reaches `IDLE_TIMEOUT-1` and valid is still low, then on that edge:
  - pulse `timeout_pulse`;
  - set `rr_ptr <= grant_id+1`;
  - go to `ARB`.
- **Width rules**
  - `beat_cnt` is $clog2(MAX_BURST+1) bits; `idle_cnt` is $clog2(IDLE_TIMEOUT+1) bits.
  - `rr_ptr` increments with explicit wrap at N_REQ-1 to 0; no reliance on power-of-2 overflow.
- **Boundary cases**
  - `req_last` and the `MAX_BURST` limit on the same beat give a single release.
  - `fifo_w_full` held indefinitely keeps the grant; no timeout.
  - A requester lowering valid mid-packet keeps the grant until `last` or timeout.
  - If the only valid requester is the one just released, it is re-granted after one `ARB` cycle.
  - Asserting `rst` mid-burst forces `ARB` asynchronously, which drops `req_ready`/`fifo_w_inc` immediately; a beat coinciding with the reset edge is not accepted.

## Timing
- Arbitration latency is one cycle: valid seen in `ARB` at cycle t, first transfer possible at t+1.
- There is one bubble cycle (`ARB`) between consecutive bursts. Maximum throughput per grant is `MAX_BURST/(MAX_BURST+1)`.
- `req_ready`, `fifo_w_inc` and `fifo_w_data` are combinational from registered state plus `fifo_w_full`/`req_valid`/`req_data`. There is no registered data stage.
- `grant_vld` is high exactly in `BURST`.
- Reset values:
  - `grant_vld=0`, `grant_id=0`, `timeout_pulse=0`;
  - `fifo_w_inc=0`, `fifo_w_data=0`, `req_ready=0`.

## Structure
- Shared package `fifo_arb_pkg`:
  - the `arb_state_t` enum (`ARB`, `BURST`);
  - the function `rr_next(ptr, n)` that implements the wrap.
- One sub-module, `rr_pick`: combinational round-robin priority picker.
  - Inputs are the valid vector and `rr_ptr`.
  - Outputs are `any` and `idx`.
  - It is reusable for the read-side scheduler.

## Test plan
Bench configuration for all scenarios: N_REQ=3, D_WIDTH=8, MAX_BURST=4, IDLE_TIMEOUT=8.
- **Fairness:** all three requesters continuously valid with 2-beat packets -> grant order 0,1,2,0; 2 data beats then 1 bubble per grant.
- **Beat limit:** req 1 sends 6 beats 0xA0..0xA5 with no last -> 0xA0..0xA3 written; `ARB` cycle; req 1 re-granted (sole requester); 0xA4, 0xA5 follow.
- **Full stall:** `fifo_w_full` held high 20 cycles mid-burst with valid high -> `fifo_w_inc=0`, grant held, no `timeout_pulse`; writing resumes the cycle full drops.
- **Timeout:** grant to req 2, valid drops after 1 beat -> `timeout_pulse` exactly 8 cycles later; next grant goes to req 0 if valid.
- **Reset mid-burst:** assert `rst` during beat 2 of a burst from req 0 -> outputs 0 asynchronously; after release the first grant goes to req 0 (`rr_ptr=0`).
- **Last and limit together:** `req_last` on beat 4 -> one release; `rr_ptr` advances once.
